// File: rtl/game_session_ctrl_if.sv
// Signal bundle between the sudoku session sequencer and its environment.
// The master side drives buttons, board events and stopwatch time; the slave side is the sequencer.
interface game_session_ctrl_if;
  logic       start_btn;
  logic       pause_btn;
  logic       board_solved;
  logic       err_pulse;
  logic [5:0] sw_seconds;
  logic [4:0] sw_minutes;
  logic       sw_run;
  logic       sw_clear;
  logic [2:0] state;
  logic [3:0] errors;
  logic [4:0] best_min;
  logic [5:0] best_sec;
  logic       best_valid;
  logic       new_record;

  modport master (
    output start_btn, pause_btn, board_solved, err_pulse, sw_seconds, sw_minutes,
    input  sw_run, sw_clear, state, errors, best_min, best_sec, best_valid, new_record
  );

  modport slave (
    input  start_btn, pause_btn, board_solved, err_pulse, sw_seconds, sw_minutes,
    output sw_run, sw_clear, state, errors, best_min, best_sec, best_valid, new_record
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Session sequencer for the sudoku game: stopwatch run/clear, time and mistake limits.
// Best-time tracking is built only when GAME_SESSION_BEST_TIME_EN is defined.
module game_session_ctrl #(
  parameter int LIMIT_MIN  = 30,
  parameter int MAX_ERRORS = 3,
  parameter int CLR_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  game_session_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PLAYING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_WON     = 3'd4,
    ST_LOST    = 3'd5
  } state_t;

  localparam logic [4:0] LIMIT_MIN_C = 5'(LIMIT_MIN);
  localparam logic [3:0] MAX_ERR_C   = 4'(MAX_ERRORS);
  localparam logic [3:0] CLR_LOAD_C  = 4'(CLR_CYCLES - 1);

  state_t     state_r;
  state_t     state_nx_s;
  logic [3:0] clr_cnt_r;
  logic [3:0] clr_cnt_nx_s;
  logic [3:0] errors_r;
  logic [3:0] errors_nx_s;
  logic [3:0] err_inc_s;
  logic       sw_run_r;
  logic       sw_clear_r;
  logic       start_q_r;
  logic       pause_q_r;
  logic       start_ev_s;
  logic       pause_ev_s;
  logic       limit_hit_s;
  logic       enter_clear_s;
  logic       win_s;

  assign start_ev_s  = bus.start_btn & ~start_q_r;
  assign pause_ev_s  = bus.pause_btn & ~pause_q_r;
  assign limit_hit_s = (bus.sw_minutes >= LIMIT_MIN_C);
  assign err_inc_s   = errors_r + 4'd1;

  // A restart only wins in PLAYING when no higher-priority event is present.
  always_comb begin
    case (state_r)
      ST_IDLE, ST_PAUSED, ST_WON, ST_LOST: enter_clear_s = start_ev_s;
      ST_PLAYING: enter_clear_s = start_ev_s & ~bus.board_solved & ~limit_hit_s & ~bus.err_pulse;
      default:    enter_clear_s = 1'b0;
    endcase
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_nx_s   = state_r;
    clr_cnt_nx_s = clr_cnt_r;
    errors_nx_s  = errors_r;
    win_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enter_clear_s) begin
          state_nx_s = ST_CLEAR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == 4'd0) begin
          state_nx_s = ST_PLAYING;
        end else begin
          state_nx_s   = ST_CLEAR;
          clr_cnt_nx_s = clr_cnt_r - 4'd1;
        end
      end
      ST_PLAYING: begin
        if (bus.board_solved) begin
          state_nx_s = ST_WON;
          win_s      = 1'b1;
        end else if (limit_hit_s) begin
          state_nx_s = ST_LOST;
        end else if (bus.err_pulse) begin
          errors_nx_s = err_inc_s;
          if (err_inc_s == MAX_ERR_C) begin
            state_nx_s = ST_LOST;
          end else begin
            state_nx_s = ST_PLAYING;
          end
        end else if (enter_clear_s) begin
          state_nx_s = ST_CLEAR;
        end else if (pause_ev_s) begin
          state_nx_s = ST_PAUSED;
        end else begin
          state_nx_s = ST_PLAYING;
        end
      end
      ST_PAUSED: begin
        if (enter_clear_s) begin
          state_nx_s = ST_CLEAR;
        end else if (pause_ev_s) begin
          state_nx_s = ST_PLAYING;
        end else begin
          state_nx_s = ST_PAUSED;
        end
      end
      ST_WON: begin
        if (enter_clear_s) begin
          state_nx_s = ST_CLEAR;
        end else begin
          state_nx_s = ST_WON;
        end
      end
      ST_LOST: begin
        if (enter_clear_s) begin
          state_nx_s = ST_CLEAR;
        end else begin
          state_nx_s = ST_LOST;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and stopwatch controls; run/clear are decoded from the next state
  // so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      clr_cnt_r  <= 4'd0;
      errors_r   <= 4'd0;
      sw_run_r   <= 1'b0;
      sw_clear_r <= 1'b0;
      start_q_r  <= 1'b1;
      pause_q_r  <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      sw_run_r   <= (state_nx_s == ST_PLAYING);
      sw_clear_r <= (state_nx_s == ST_CLEAR);
      start_q_r  <= bus.start_btn;
      pause_q_r  <= bus.pause_btn;
      if (enter_clear_s) begin
        clr_cnt_r <= CLR_LOAD_C;
        errors_r  <= 4'd0;
      end else begin
        clr_cnt_r <= clr_cnt_nx_s;
        errors_r  <= errors_nx_s;
      end
    end
  end

  assign bus.state    = state_r;
  assign bus.sw_run   = sw_run_r;
  assign bus.sw_clear = sw_clear_r;
  assign bus.errors   = errors_r;

`ifdef GAME_SESSION_BEST_TIME_EN
  logic [4:0]  best_min_r;
  logic [5:0]  best_sec_r;
  logic        best_valid_r;
  logic        new_record_r;
  logic [10:0] captured_s;

  assign captured_s = {bus.sw_minutes, bus.sw_seconds};

  // Best solve time; a tie with the stored best is not a record.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_min_r   <= 5'd0;
      best_sec_r   <= 6'd0;
      best_valid_r <= 1'b0;
      new_record_r <= 1'b0;
    end else if (enter_clear_s) begin
      new_record_r <= 1'b0;
    end else if (win_s) begin
      if (!best_valid_r || (captured_s < {best_min_r, best_sec_r})) begin
        best_min_r   <= bus.sw_minutes;
        best_sec_r   <= bus.sw_seconds;
        best_valid_r <= 1'b1;
        new_record_r <= 1'b1;
      end else begin
        new_record_r <= 1'b0;
      end
    end else begin
      new_record_r <= new_record_r;
    end
  end

  assign bus.best_min   = best_min_r;
  assign bus.best_sec   = best_sec_r;
  assign bus.best_valid = best_valid_r;
  assign bus.new_record = new_record_r;
`else
  assign bus.best_min   = 5'd0;
  assign bus.best_sec   = 6'd0;
  assign bus.best_valid = 1'b0;
  assign bus.new_record = 1'b0;
`endif

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: directed scenarios with literal expectations,
// then random stimulus compared every cycle against a behavioural session model.
module tb_game_session_ctrl;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_PLAY = 2, P_PAUSE = 3, P_WON = 4, P_LOST = 5;
  localparam int LIMIT = 30, MAXERR = 3, CLRN = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  game_session_ctrl_if bus ();

  game_session_ctrl #(.LIMIT_MIN(LIMIT), .MAX_ERRORS(MAXERR), .CLR_CYCLES(CLRN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int m_state, m_err, m_clr_left, m_best_s, m_best_min, m_best_sec;
  bit m_best_valid, m_new_rec, m_start_prev, m_pause_prev;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit sev, pev, go_clear;
    int t;
    if (reset) begin
      m_state = P_IDLE; m_err = 0; m_clr_left = 0;
      m_best_valid = 0; m_best_min = 0; m_best_sec = 0; m_best_s = 0; m_new_rec = 0;
      m_start_prev = 1; m_pause_prev = 1;
      return;
    end
    sev = bus.start_btn && !m_start_prev;
    pev = bus.pause_btn && !m_pause_prev;
    m_start_prev = bus.start_btn;
    m_pause_prev = bus.pause_btn;
    go_clear = 0;
    if (m_state == P_IDLE) begin
      go_clear = sev;
    end else if (m_state == P_CLEAR) begin
      m_clr_left--;
      if (m_clr_left == 0) m_state = P_PLAY;
    end else if (m_state == P_PLAY) begin
      if (bus.board_solved) begin
        m_state = P_WON;
        t = bus.sw_minutes * 60 + bus.sw_seconds;
        if (!m_best_valid || t < m_best_s) begin
          m_best_s = t; m_best_min = bus.sw_minutes; m_best_sec = bus.sw_seconds;
          m_best_valid = 1; m_new_rec = 1;
        end else begin
          m_new_rec = 0;
        end
      end else if (bus.sw_minutes >= LIMIT) begin
        m_state = P_LOST;
      end else if (bus.err_pulse) begin
        m_err++;
        if (m_err == MAXERR) m_state = P_LOST;
      end else if (sev) begin
        go_clear = 1;
      end else if (pev) begin
        m_state = P_PAUSE;
      end
    end else if (m_state == P_PAUSE) begin
      if (sev) go_clear = 1;
      else if (pev) m_state = P_PLAY;
    end else begin
      go_clear = sev;
    end
    if (go_clear) begin
      m_state = P_CLEAR; m_clr_left = CLRN; m_err = 0; m_new_rec = 0;
    end
  endtask

  always @(posedge clk) model_step();

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    check("state", bus.state, m_state);
    check("sw_run", bus.sw_run, (m_state == P_PLAY) ? 1 : 0);
    check("sw_clear", bus.sw_clear, (m_state == P_CLEAR) ? 1 : 0);
    check("errors", bus.errors, m_err);
`ifdef GAME_SESSION_BEST_TIME_EN
    check("best_min", bus.best_min, m_best_min);
    check("best_sec", bus.best_sec, m_best_sec);
    check("best_valid", bus.best_valid, m_best_valid);
    check("new_record", bus.new_record, m_new_rec);
`else
    check("best_min", bus.best_min, 0);
    check("best_sec", bus.best_sec, 0);
    check("best_valid", bus.best_valid, 0);
    check("new_record", bus.new_record, 0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.start_btn = 0; bus.pause_btn = 0; bus.board_solved = 0; bus.err_pulse = 0;
    bus.sw_minutes = 5'd0; bus.sw_seconds = 6'd0;
  endtask

  task automatic go_play();
    quiet();
    bus.start_btn = 1; tick();
    check("lit_clear_state", bus.state, P_CLEAR);
    check("lit_clear_err0", bus.errors, 0);
    bus.start_btn = 0; tick();
    check("lit_clear2_sw_clear", bus.sw_clear, 1);
    tick();
    check("lit_play_run", bus.sw_run, 1);
  endtask

  task automatic win_at(input int mn, input int sc);
    go_play();
    bus.sw_minutes = 5'(mn); bus.sw_seconds = 6'(sc); bus.board_solved = 1;
    tick();
    check("lit_won", bus.state, P_WON);
    bus.board_solved = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    quiet();
    // start held through reset must not register as an edge
    reset = 1; bus.start_btn = 1;
    tick(); tick();
    check("lit_reset_state", bus.state, P_IDLE);
    check("lit_reset_run", bus.sw_run, 0);
    reset = 0;
    tick(); tick();
    check("lit_held_start_idle", bus.state, P_IDLE);
    bus.start_btn = 0; tick();

    // start pulse: two CLEAR cycles, then PLAYING
    bus.start_btn = 1; tick();
    check("lit_clr1", bus.sw_clear, 1);
    bus.start_btn = 0; tick();
    check("lit_clr2", bus.sw_clear, 1);
    tick();
    check("lit_playing", bus.state, P_PLAY);
    check("lit_clr_done", bus.sw_clear, 0);

    // pause held: a single toggle, then a fresh press resumes
    bus.pause_btn = 1;
    for (int i = 0; i < 5; i++) tick();
    check("lit_paused", bus.state, P_PAUSE);
    check("lit_paused_run", bus.sw_run, 0);
    bus.pause_btn = 0; tick();
    bus.pause_btn = 1; tick();
    check("lit_resumed", bus.state, P_PLAY);
    bus.pause_btn = 0; tick();

    // mistakes up to the limit, then one extra
    for (int i = 1; i <= 4; i++) begin
      bus.err_pulse = 1; tick();
      bus.err_pulse = 0;
      check("lit_errors", bus.errors, (i > 3) ? 3 : i);
      check("lit_err_state", bus.state, (i >= 3) ? P_LOST : P_PLAY);
      tick();
    end

    // time limit, and solve on the limit cycle
    go_play();
    bus.sw_minutes = 5'd30; tick();
    check("lit_time_lost", bus.state, P_LOST);
    check("lit_time_lost_run", bus.sw_run, 0);
    win_at(30, 0);

    // best-time sequence
    win_at(5, 10);
    win_at(4, 59);
`ifdef GAME_SESSION_BEST_TIME_EN
    check("lit_best_min", bus.best_min, 4);
    check("lit_best_sec", bus.best_sec, 59);
    check("lit_new_rec", bus.new_record, 1);
`endif
    win_at(4, 59);
`ifdef GAME_SESSION_BEST_TIME_EN
    check("lit_tie_min", bus.best_min, 4);
    check("lit_tie_sec", bus.best_sec, 59);
    check("lit_tie_rec", bus.new_record, 0);
`else
    check("lit_nobest_valid", bus.best_valid, 0);
    check("lit_nobest_min", bus.best_min, 0);
`endif

    // reset while paused with two mistakes
    go_play();
    bus.err_pulse = 1; tick(); tick();
    bus.err_pulse = 0;
    bus.pause_btn = 1; tick();
    check("lit_pause_err2", bus.errors, 2);
    reset = 1; tick();
    check("lit_rst_idle", bus.state, P_IDLE);
    check("lit_rst_err0", bus.errors, 0);
    reset = 0; quiet(); tick();

    // random phase against the model
    for (int i = 0; i < 4000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      bus.start_btn    = ($urandom_range(0, 19) == 0);
      bus.pause_btn    = ($urandom_range(0, 5) == 0);
      bus.err_pulse    = ($urandom_range(0, 15) == 0);
      bus.board_solved = ($urandom_range(0, 39) == 0);
      bus.sw_seconds   = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 29) == 0) bus.sw_minutes = 5'($urandom_range(0, 31));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
